// File: rtl/y86_execute_pipe.sv
// Y86 execute stage: ALU, condition-code register, branch/move condition and the E/M
// pipeline register with stall (hold) and bubble (reset-value load).
module y86_execute_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             cc_block,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             e_cnd,
  output logic             m_valid,
  output logic [3:0]       m_icode,
  output logic             m_cnd,
  output logic [WIDTH-1:0] m_valE,
  output logic [WIDTH-1:0] m_valA,
  output logic [3:0]       m_dstE,
  output logic [3:0]       m_dstM,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] ICmov   = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;
  localparam logic [WIDTH-1:0] Step = WIDTH'(STACK_STEP);

  logic [WIDTH-1:0] val_e;
  logic             zf_new, sf_new, of_new;
  logic             sign_a, sign_b, sign_e;
  logic             cond, cc_update;
  logic             zf_q, sf_q, of_q, zf_d, sf_d, of_d;

  logic             valid_q, valid_d, cnd_q, cnd_d;
  logic [3:0]       icode_q, icode_d, dst_e_q, dst_e_d, dst_m_q, dst_m_d;
  logic [WIDTH-1:0] val_e_q, val_e_d, val_a_q, val_a_d;

  always_comb begin
    val_e = '0;
    case (e_icode)
      ICmov:            val_e = e_valA;
      IIrmovq:          val_e = e_valC;
      IRmmovq, IMrmovq: val_e = e_valB + e_valC;
      IOpq: begin
        case (e_ifun)
          4'd0:    val_e = e_valB + e_valA;
          4'd1:    val_e = e_valB - e_valA;
          4'd2:    val_e = e_valB & e_valA;
          4'd3:    val_e = e_valB ^ e_valA;
          default: val_e = '0;
        endcase
      end
      ICall, IPushq:    val_e = e_valB - Step;
      IRet, IPopq:      val_e = e_valB + Step;
      default:          val_e = '0;
    endcase
  end

  assign sign_a = e_valA[WIDTH-1];
  assign sign_b = e_valB[WIDTH-1];
  assign sign_e = val_e[WIDTH-1];
  assign zf_new = (val_e == '0);
  assign sf_new = sign_e;

  always_comb begin
    of_new = 1'b0;
    if (e_ifun == 4'd0) begin
      of_new = (sign_a == sign_b) && (sign_e != sign_b);
    end else if (e_ifun == 4'd1) begin
      of_new = (sign_a != sign_b) && (sign_e != sign_b);
    end
  end

  assign cc_update = e_valid && (e_icode == IOpq) && (e_ifun <= 4'd3) && !cc_block && !m_stall;

  // Condition is taken from the registered flags only, never from this cycle's ALU result.
  always_comb begin
    case (e_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (sf_q ^ of_q) | zf_q;
      4'd2:    cond = sf_q ^ of_q;
      4'd3:    cond = zf_q;
      4'd4:    cond = ~zf_q;
      4'd5:    cond = ~(sf_q ^ of_q);
      4'd6:    cond = ~(sf_q ^ of_q) & ~zf_q;
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd = ((e_icode == ICmov) || (e_icode == IJxx)) ? cond : 1'b1;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_update) begin
      zf_d = zf_new;
      sf_d = sf_new;
      of_d = of_new;
    end
  end

  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    val_e_d = val_e_q;
    val_a_d = val_a_q;
    dst_e_d = dst_e_q;
    dst_m_d = dst_m_q;
    if (!m_stall) begin
      if (m_bubble || !e_valid) begin
        valid_d = 1'b0;
        icode_d = INop;
        cnd_d   = 1'b0;
        val_e_d = '0;
        val_a_d = '0;
        dst_e_d = RNone;
        dst_m_d = RNone;
      end else begin
        valid_d = 1'b1;
        icode_d = e_icode;
        cnd_d   = e_cnd;
        val_e_d = val_e;
        val_a_d = e_valA;
        dst_e_d = ((e_icode == ICmov) && !cond) ? RNone : e_dstE;
        dst_m_d = e_dstM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      icode_q <= INop;
      cnd_q   <= 1'b0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= RNone;
      dst_m_q <= RNone;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign m_valid = valid_q;
  assign m_icode = icode_q;
  assign m_cnd   = cnd_q;
  assign m_valE  = val_e_q;
  assign m_valA  = val_a_q;
  assign m_dstE  = dst_e_q;
  assign m_dstM  = dst_m_q;
  assign cc_zf   = zf_q;
  assign cc_sf   = sf_q;
  assign cc_of   = of_q;

endmodule
